axis_edge_pack: RTL and testbench

- Downstream consumer of the Sobel pipeline's AXI-Stream magnitude output. Tdata is the unsigned gradient magnitude; tuser marks start of frame; tlast marks end of line.
- Binarizes each magnitude against a per-frame threshold and packs 8 edge bits per output byte, LSB = leftmost pixel.
- Produces an 8-bit AXI-Stream with line and frame markers preserved, for a narrow display or transport link.
- Also checks line length and resynchronizes to frame start.

---
 rtl/axis_edge_pack.sv | 144 ++++++++++++++
 tb/tb_axis_edge_pack.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_edge_pack.sv
// axis_edge_pack: binarize Sobel magnitudes, pack 8 edge bits per byte.
// Optional per-frame edge counter under `define EDGE_PACK_STATS_EN.
module axis_edge_pack #(
  parameter int WIDTH_P  = 16,
  parameter int LINE_W_P = 640
`ifdef EDGE_PACK_STATS_EN
  ,
  parameter int CNT_W_P  = 20
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH_P-1:0] thresh_i,
  input  logic [WIDTH_P-1:0] s_tdata_i,
  input  logic               s_tuser_i,
  input  logic               s_tlast_i,
  input  logic               s_tvalid_i,
  output logic               s_tready_o,
  output logic [7:0]         m_tdata_o,
  output logic               m_tkeep_o,
  output logic               m_tuser_o,
  output logic               m_tlast_o,
  output logic               m_tvalid_o,
  input  logic               m_tready_i,
  output logic               err_len_o
`ifdef EDGE_PACK_STATS_EN
  ,
  output logic [CNT_W_P-1:0] edge_cnt_o,
  output logic               edge_cnt_valid_o
`endif
);

  typedef enum logic {SYNC, ACTIVE} state_t;

  localparam int XW = (LINE_W_P > 1) ? $clog2(LINE_W_P) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(LINE_W_P - 1);

  state_t             state_q;
  logic [7:0]         acc_q;
  logic [2:0]         idx_q;
  logic [XW-1:0]      x_q;
  logic [WIDTH_P-1:0] thr_q;
  logic               sof_q;

  logic               accept;
  logic               restart;
  logic               live;
  logic               edge_bit;
  logic [7:0]         acc_b;
  logic [2:0]         idx_b;
  logic [XW-1:0]      x_b;
  logic               sof_b;
  logic               at_end;
  logic               line_end;
  logic               emit;
  logic [7:0]         acc_n;
  logic               err;

  assign s_tready_o = ~(m_tvalid_o & ~m_tready_i);
  assign m_tkeep_o  = 1'b1;

  // A tuser beat restarts from a clean slate and is itself pixel 0.
  always_comb begin
    accept   = s_tvalid_i & s_tready_o;
    restart  = s_tuser_i;
    live     = accept & (restart | (state_q == ACTIVE));
    edge_bit = s_tdata_i >= (restart ? thresh_i : thr_q);
    acc_b    = restart ? 8'd0 : acc_q;
    idx_b    = restart ? 3'd0 : idx_q;
    x_b      = restart ? '0 : x_q;
    sof_b    = restart | sof_q;
    at_end   = (x_b == X_LAST);
    line_end = s_tlast_i | at_end;
    emit     = line_end | (idx_b == 3'd7);
    acc_n    = acc_b | (8'(edge_bit) << idx_b);
    err      = (s_tlast_i ^ at_end)
             | (restart & (state_q == ACTIVE) & (x_q != '0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= SYNC;
      acc_q      <= '0;
      idx_q      <= '0;
      x_q        <= '0;
      thr_q      <= '0;
      sof_q      <= 1'b0;
      m_tdata_o  <= '0;
      m_tuser_o  <= 1'b0;
      m_tlast_o  <= 1'b0;
      m_tvalid_o <= 1'b0;
      err_len_o  <= 1'b0;
    end else begin
      err_len_o <= 1'b0;
      if (m_tready_i) m_tvalid_o <= 1'b0;
      if (live) begin
        state_q   <= ACTIVE;
        err_len_o <= err;
        if (restart) thr_q <= thresh_i;
        if (emit) begin
          m_tvalid_o <= 1'b1;
          m_tdata_o  <= acc_n;
          m_tuser_o  <= sof_b;
          m_tlast_o  <= line_end;
          acc_q      <= '0;
          idx_q      <= '0;
          sof_q      <= 1'b0;
          x_q        <= line_end ? '0 : x_b + 1'b1;
        end else begin
          acc_q <= acc_n;
          idx_q <= idx_b + 3'd1;
          sof_q <= sof_b;
          x_q   <= x_b + 1'b1;
        end
      end
    end
  end

`ifdef EDGE_PACK_STATS_EN
  logic [CNT_W_P-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q            <= '0;
      edge_cnt_o       <= '0;
      edge_cnt_valid_o <= 1'b0;
    end else begin
      edge_cnt_valid_o <= 1'b0;
      if (live) begin
        if (restart) begin
          if (state_q == ACTIVE) begin
            edge_cnt_o       <= cnt_q;
            edge_cnt_valid_o <= 1'b1;
          end
          cnt_q <= CNT_W_P'(edge_bit);
        end else if (edge_bit && (cnt_q != '1)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_edge_pack.sv
// Directed bench for axis_edge_pack with a byte scoreboard.
// Stats checks are compiled in when EDGE_PACK_STATS_EN is defined.
module tb_axis_edge_pack;

  localparam int W = 16;
  localparam int L = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] thresh = '0;
  logic [W-1:0] s_tdata = '0;
  logic         s_tuser = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [7:0]   m_tdata;
  logic         m_tkeep;
  logic         m_tuser;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic         err_len;
`ifdef EDGE_PACK_STATS_EN
  logic [19:0]  edge_cnt;
  logic         edge_cnt_valid;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int n_err = 0;
  int n_stat = 0;
  int last_cnt = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  axis_edge_pack #(.WIDTH_P(W), .LINE_W_P(L)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .thresh_i   (thresh),
    .s_tdata_i  (s_tdata),
    .s_tuser_i  (s_tuser),
    .s_tlast_i  (s_tlast),
    .s_tvalid_i (s_tvalid),
    .s_tready_o (s_tready),
    .m_tdata_o  (m_tdata),
    .m_tkeep_o  (m_tkeep),
    .m_tuser_o  (m_tuser),
    .m_tlast_o  (m_tlast),
    .m_tvalid_o (m_tvalid),
    .m_tready_i (m_tready),
    .err_len_o  (err_len)
`ifdef EDGE_PACK_STATS_EN
    ,
    .edge_cnt_o       (edge_cnt),
    .edge_cnt_valid_o (edge_cnt_valid)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic u, input logic l);
    sb.push_back({u, l, d});
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input int d, input logic u, input logic l);
    int n;
    logic ok;
    s_tvalid = 1'b1;
    s_tdata  = W'(d);
    s_tuser  = u;
    s_tlast  = l;
    n = 0;
    do begin
      @(negedge clk);
      ok = s_tready;
      n++;
    end while (!ok && n < 200);
    if (!ok) check("send_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_tvalid) break;
    end
    check("drain", 32'(sb.size()), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (err_len) n_err++;
`ifdef EDGE_PACK_STATS_EN
      if (edge_cnt_valid) begin
        n_stat++;
        last_cnt = int'(edge_cnt);
      end
`endif
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          check("extra_byte", 32'(sb.size()), 1);
        end else begin
          check("byte", {22'd0, m_tuser, m_tlast, m_tdata}, 32'(sb.pop_front()));
          check("tkeep", 32'(m_tkeep), 1);
        end
      end
    end
  end

  initial begin
    int e0;
    int s0;
    time t0;
    logic [7:0] held;

    repeat (3) @(negedge clk);
    check("rst_tvalid", 32'(m_tvalid), 0);
    check("rst_tready", 32'(s_tready), 1);
    check("rst_tdata", 32'(m_tdata), 0);
    check("rst_tuser", 32'(m_tuser), 0);
    check("rst_tlast", 32'(m_tlast), 0);
    check("rst_err", 32'(err_len), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Non-tuser beats while searching for frame start are dropped.
    e0 = n_err;
    for (int i = 0; i < 3; i++) send(255, 1'b0, 1'b0);
    drain();
    check("sync_err", 32'(n_err - e0), 0);

    // Two lines alternating 150/50; mid-frame thresh change is ignored.
    thresh = 100;
    push(8'h55, 1, 0); push(8'h55, 0, 1);
    push(8'h55, 0, 0); push(8'h55, 0, 1);
    for (int i = 0; i < 2 * L; i++) begin
      if (i == L) thresh = 255;
      send((i % 2 == 0) ? 150 : 50, i == 0, (i % L) == L - 1);
    end
    drain();
    check("alt_err", 32'(n_err - e0), 0);

    // Full line of 200 at one pixel per cycle.
    push(8'hFF, 0, 0); push(8'hFF, 0, 1);
    t0 = $time;
    for (int i = 0; i < L; i++) send(200, 1'b0, i == L - 1);
    check("throughput", 32'(($time - t0) / 10), L);
    drain();
    check("full_err", 32'(n_err - e0), 0);

    // Short line, then a normal line starting back at x=0.
    push(8'h3F, 0, 1);
    push(8'h00, 0, 0); push(8'h00, 0, 1);
    for (int i = 0; i < 6; i++) send(255, 1'b0, i == 5);
    for (int i = 0; i < L; i++) send(0, 1'b0, i == L - 1);
    drain();
    check("short_err", 32'(n_err - e0), 1);

    // Missing tlast: line forced to end at LINE_W_P pixels.
    push(8'hFF, 0, 0); push(8'hFF, 0, 1);
    for (int i = 0; i < L; i++) send(255, 1'b0, 1'b0);
    drain();
    check("forced_err", 32'(n_err - e0), 2);

    // Backpressure on the first byte for 10 cycles.
    push(8'hE0, 0, 0); push(8'hFF, 0, 1);
    m_tready = 1'b0;
    fork
      for (int i = 0; i < L; i++) send(i * 20, 1'b0, i == L - 1);
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (m_tvalid) break;
        end
        check("bp_valid", 32'(m_tvalid), 1);
        held = m_tdata;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("bp_tready", 32'(s_tready), 0);
          check("bp_stable", 32'(m_tdata), 32'(held));
        end
        @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();
    check("bp_err", 32'(n_err - e0), 2);

    // Mid-line tuser drops the partial byte and restarts the frame.
    push(8'h01, 1, 0); push(8'hFF, 0, 1);
    for (int i = 0; i < 3; i++) send(255, 1'b0, 1'b0);
    thresh = 50;
    send(60, 1'b1, 1'b0);
    thresh = 100;
    for (int i = 1; i < 8; i++) send(40, 1'b0, 1'b0);
    for (int i = 8; i < L; i++) send(50, 1'b0, i == L - 1);
    drain();
    check("restart_err", 32'(n_err - e0), 3);

    // tuser and tlast on the same beat.
    push(8'h01, 1, 1);
    thresh = 50;
    send(60, 1'b1, 1'b1);
    drain();
    check("ul_err", 32'(n_err - e0), 4);

    // Frame with 37 edge pixels, closed by the next tuser.
    thresh = 100;
    push(8'hFF, 1, 0); push(8'hFF, 0, 1);
    push(8'hFF, 0, 0); push(8'hFF, 0, 1);
    push(8'h1F, 0, 0); push(8'h00, 0, 1);
    for (int i = 0; i < 3 * L; i++)
      send((i < 37) ? 255 : 0, i == 0, (i % L) == L - 1);
    drain();
    s0 = n_stat;
    send(0, 1'b1, 1'b0);
    drain();
    check("stats_err", 32'(n_err - e0), 4);
`ifdef EDGE_PACK_STATS_EN
    check("stat_pulse", 32'(n_stat - s0), 1);
    check("stat_cnt", 32'(last_cnt), 37);
`endif

    // Reset drops a held output byte and returns to SYNC.
    m_tready = 1'b0;
    send(255, 1'b1, 1'b1);
    @(negedge clk);
    check("pre_rst_valid", 32'(m_tvalid), 1);
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(m_tvalid), 0);
    check("arst_tready", 32'(s_tready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_tready = 1'b1;
    send(255, 1'b0, 1'b1);
    drain();
    check("post_rst_q", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
